pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports (name direction width meaning):
- CLK  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ID_RsAdr / ID_RtAdr  in  5  source register addresses of the instruction in ID.
- ID_UsesRs / ID_UsesRt  in  1  the ID instruction reads Rs / Rt.
- EX_Eff, EX_RegWrite, EX_MemToReg  in  1  valid, writes register, is a load (EX stage).
- EX_WAdr  in  5  destination register of the EX instruction.
- EX_Mispredict  in  1  BTB prediction wrong; PC redirect is supplied this cycle.
- WB_Eff, WB_Halt  in  1  WB instruction is valid; WB instruction is the halt syscall.
- WB_PC_plus_four  in  32  PC+4 of the WB instruction.
- Go  in  1  resume request, level input, edge-detected internally.
- PC_En, IFID_En  out  1  load enables for PC and IF/ID.
- IFID_Clr, IDEX_Clr, EXMEM_Clr  out  1  synchronous bubble insert for those registers.
- MemWB_Kill  out  1  forces Eff_in of MEM/WB to 0.
- Resume_Sel  out  1  PC mux selects ResumePC.
- ResumePC  out  32  registered restart address.
- Halted  out  1  state == HALT.
- State  out  2  RUN=0, HALT=1, RESUME=2.
- CycleCnt  out  32; StallCnt, FlushCnt  out  16  statistics counters.

Function
REQ-002 SHALL implement states RUN, HALT and RESUME; encoding 3 is unreachable and SHALL return to RUN on the next edge.
REQ-003 SHALL raise halt_hit = WB_Eff & WB_Halt, evaluated in RUN only.
REQ-004 SHALL raise load_use = EX_Eff & EX_RegWrite & EX_MemToReg & (EX_WAdr != 0) & ((ID_UsesRs & ID_RsAdr == EX_WAdr) | (ID_UsesRt & ID_RtAdr == EX_WAdr)).
REQ-005 Priority in RUN SHALL be halt_hit > EX_Mispredict > load_use. All control outputs SHALL be combinational on the current state and inputs, with zero latency.
REQ-006 RUN defaults: PC_En=1, IFID_En=1, all Clr=0, MemWB_Kill=0, Resume_Sel=0.
REQ-007 RUN, load_use only: PC_En=0, IFID_En=0, IDEX_Clr=1, for exactly one cycle per detection.
REQ-008 RUN, EX_Mispredict: PC_En=1, IFID_Clr=1, IDEX_Clr=1, IFID_En=1. A simultaneous load_use SHALL be ignored.
REQ-009 RUN, halt_hit, same cycle: PC_En=0, IFID_En=0, IFID_Clr=IDEX_Clr=EXMEM_Clr=1, MemWB_Kill=1.
- ResumePC <= WB_PC_plus_four.
- Next state HALT.
REQ-010 HALT: PC_En=0, IFID_En=0, all Clr=1, MemWB_Kill=1, Halted=1.
- go_rise = Go & ~Go_q, where Go_q is Go registered every cycle.
- go_rise SHALL cause the transition to RESUME; a Go held high from before HALT entry SHALL NOT resume.
REQ-011 RESUME, exactly one cycle: PC_En=1, Resume_Sel=1, all Clr=1, MemWB_Kill=1, IFID_En=0. Next state RUN.
REQ-012 CycleCnt SHALL increment by 1 on each edge with state != HALT, wrapping modulo 2^32.
REQ-013 StallCnt SHALL increment on each cycle REQ-007 applies; FlushCnt SHALL increment on each cycle REQ-008 applies. Both SHALL saturate at 0xFFFF.
REQ-014 ResumePC SHALL change only on halt_hit.

Reset
REQ-015 Reset asserted SHALL asynchronously set State=RUN, Go_q=0, ResumePC=0, and all counters to 0.
REQ-016 While Reset=1, outputs SHALL be: PC_En=0, IFID_En=0, all Clr=1, MemWB_Kill=1, Resume_Sel=0, Halted=0.
REQ-017 Reset during HALT or RESUME SHALL return to RUN with counters cleared; the first cycle after release SHALL follow REQ-006.

Verification
REQ-018 Load-use: EX load, EX_WAdr=5, ID_RsAdr=5, ID_UsesRs=1 -> one cycle with PC_En=0, IDEX_Clr=1; StallCnt 0->1. Repeat with EX_WAdr=0 -> no stall.
REQ-019 Mispredict and load_use in the same cycle -> IFID_Clr=IDEX_Clr=1, PC_En=1; FlushCnt+1, StallCnt unchanged.
REQ-020 Halt: WB_Eff=WB_Halt=1, WB_PC_plus_four=0x00000104 -> same cycle all Clr=1, MemWB_Kill=1; next cycle Halted=1, ResumePC=0x00000104; CycleCnt frozen.
REQ-021 Resume: Go held 1 through halt entry -> stays HALT. Go 0 then 1 -> RESUME for one cycle with Resume_Sel=1, then RUN.
REQ-022 Saturation and reset: preload StallCnt to 0xFFFE, apply 3 stalls -> StallCnt 0xFFFF. Assert Reset mid-HALT -> State=0, counters 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/halt controller: stall on load-use, flush on mispredict, halt/resume FSM.
// Control outputs are zero-latency combinational; State/ResumePC/counters are registered.
module pipe_hazard_ctrl (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [4:0]  ID_RsAdr,
    input  logic [4:0]  ID_RtAdr,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        EX_Eff,
    input  logic        EX_RegWrite,
    input  logic        EX_MemToReg,
    input  logic [4:0]  EX_WAdr,
    input  logic        EX_Mispredict,
    input  logic        WB_Eff,
    input  logic        WB_Halt,
    input  logic [31:0] WB_PC_plus_four,
    input  logic        Go,
    output logic        PC_En,
    output logic        IFID_En,
    output logic        IFID_Clr,
    output logic        IDEX_Clr,
    output logic        EXMEM_Clr,
    output logic        MemWB_Kill,
    output logic        Resume_Sel,
    output logic [31:0] ResumePC,
    output logic        Halted,
    output logic [1:0]  State,
    output logic [31:0] CycleCnt,
    output logic [15:0] StallCnt,
    output logic [15:0] FlushCnt
);
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALT   = 2'd1,
        ST_RESUME = 2'd2,
        ST_BAD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        go_q, go_d;
    logic [31:0] resume_pc_q, resume_pc_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic halt_hit, load_use, go_rise;

    assign halt_hit = WB_Eff & WB_Halt;
    assign go_rise  = Go & ~go_q;
    assign load_use = EX_Eff & EX_RegWrite & EX_MemToReg & (EX_WAdr != 5'd0) &
                      ((ID_UsesRs & (ID_RsAdr == EX_WAdr)) |
                       (ID_UsesRt & (ID_RtAdr == EX_WAdr)));

    always_comb begin
        state_d     = state_q;
        go_d        = Go;
        resume_pc_d = resume_pc_q;
        cycle_cnt_d = (state_q != ST_HALT) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        PC_En      = 1'b1;
        IFID_En    = 1'b1;
        IFID_Clr   = 1'b0;
        IDEX_Clr   = 1'b0;
        EXMEM_Clr  = 1'b0;
        MemWB_Kill = 1'b0;
        Resume_Sel = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (halt_hit) begin
                    PC_En       = 1'b0;
                    IFID_En     = 1'b0;
                    IFID_Clr    = 1'b1;
                    IDEX_Clr    = 1'b1;
                    EXMEM_Clr   = 1'b1;
                    MemWB_Kill  = 1'b1;
                    resume_pc_d = WB_PC_plus_four;
                    state_d     = ST_HALT;
                end else if (EX_Mispredict) begin
                    // Redirect wins over a stall: the stalled instruction is flushed anyway.
                    IFID_Clr    = 1'b1;
                    IDEX_Clr    = 1'b1;
                    flush_cnt_d = flush_cnt_q + {15'd0, flush_cnt_q != 16'hFFFF};
                end else if (load_use) begin
                    PC_En       = 1'b0;
                    IFID_En     = 1'b0;
                    IDEX_Clr    = 1'b1;
                    stall_cnt_d = stall_cnt_q + {15'd0, stall_cnt_q != 16'hFFFF};
                end
            end
            ST_HALT: begin
                PC_En      = 1'b0;
                IFID_En    = 1'b0;
                IFID_Clr   = 1'b1;
                IDEX_Clr   = 1'b1;
                EXMEM_Clr  = 1'b1;
                MemWB_Kill = 1'b1;
                if (go_rise) state_d = ST_RESUME;
            end
            ST_RESUME: begin
                IFID_En    = 1'b0;
                IFID_Clr   = 1'b1;
                IDEX_Clr   = 1'b1;
                EXMEM_Clr  = 1'b1;
                MemWB_Kill = 1'b1;
                Resume_Sel = 1'b1;
                state_d    = ST_RUN;
            end
            ST_BAD: begin
                PC_En      = 1'b0;
                IFID_En    = 1'b0;
                IFID_Clr   = 1'b1;
                IDEX_Clr   = 1'b1;
                EXMEM_Clr  = 1'b1;
                MemWB_Kill = 1'b1;
                state_d    = ST_RUN;
            end
        endcase

        // Reset holds every pipeline register in bubble regardless of state.
        if (Reset) begin
            PC_En      = 1'b0;
            IFID_En    = 1'b0;
            IFID_Clr   = 1'b1;
            IDEX_Clr   = 1'b1;
            EXMEM_Clr  = 1'b1;
            MemWB_Kill = 1'b1;
            Resume_Sel = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_RUN;
            go_q        <= 1'b0;
            resume_pc_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            resume_pc_q <= resume_pc_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign State    = state_q;
    assign Halted   = (state_q == ST_HALT);
    assign ResumePC = resume_pc_q;
    assign CycleCnt = cycle_cnt_q;
    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
endmodule
